// File: rtl/swap_gain_eval_pkg.sv
// Shared types, constants and the edge table for the swap gain evaluator.
package swap_gain_eval_pkg;

  typedef logic [7:0]  coord_t;
  typedef logic [8:0]  dist_t;
  typedef logic [31:0] cost_t;
  typedef logic [16:0] rad_t;

  localparam int unsigned ISQRT_ITERS = 9;
  localparam int unsigned NUM_PTS     = 6;

  typedef enum logic [1:0] {StReset, StEdge, StCmp, StDone} state_e;

  typedef struct packed {
    logic [2:0] p;
    logic [2:0] q;
  } pair_t;

  // Old-path edges come first, new-path edges second (0-based point indices).
  function automatic pair_t edge_pair(input logic adjacent, input logic [2:0] idx);
    pair_t pr;
    pr = '0;
    if (adjacent) begin
      unique case (idx[1:0])
        2'd0:    pr = {3'd0, 3'd1};
        2'd1:    pr = {3'd2, 3'd3};
        2'd2:    pr = {3'd0, 3'd2};
        default: pr = {3'd1, 3'd3};
      endcase
    end else begin
      unique case (idx)
        3'd0:    pr = {3'd0, 3'd1};
        3'd1:    pr = {3'd1, 3'd2};
        3'd2:    pr = {3'd3, 3'd4};
        3'd3:    pr = {3'd4, 3'd5};
        3'd4:    pr = {3'd0, 3'd4};
        3'd5:    pr = {3'd4, 3'd2};
        3'd6:    pr = {3'd3, 3'd1};
        default: pr = {3'd1, 3'd5};
      endcase
    end
    return pr;
  endfunction

  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a > b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/swap_gain_eval_if.sv
// Coordinate inputs and result outputs of one swap gain evaluator.
interface swap_gain_eval_if;
  import swap_gain_eval_pkg::*;

  coord_t x [NUM_PTS];
  coord_t y [NUM_PTS];
  logic   res;
  logic   complete;
  cost_t  difference;

  modport master (output x, output y, input res, input complete, input difference);
  modport slave  (input x, input y, output res, output complete, output difference);
endinterface

// File: rtl/swap_gain_eval_isqrt.sv
// Bit-serial restoring integer square root: 17b radicand to 9b floor root in 9 cycles.
module swap_gain_eval_isqrt
  import swap_gain_eval_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  rad_t  radicand,
  output logic  busy,
  output logic  done,
  output dist_t root
);
  localparam logic [3:0] LastIter = 4'(ISQRT_ITERS - 1);

  logic [17:0] rad_q;
  logic [10:0] rem_q;
  dist_t       root_q;
  logic [3:0]  cnt_q;
  logic        busy_q;

  logic [12:0] rem_sh, trial, rem_sub;
  logic [10:0] rem_n;
  dist_t       root_n;

  always_comb begin
    rem_sh  = {rem_q, rad_q[17:16]};
    trial   = {2'b00, root_q, 2'b01};
    rem_sub = rem_sh - trial;
    if (rem_sh >= trial) begin
      rem_n  = rem_sub[10:0];
      root_n = {root_q[7:0], 1'b1};
    end else begin
      rem_n  = rem_sh[10:0];
      root_n = {root_q[7:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rad_q  <= {1'b0, radicand};
      rem_q  <= '0;
      root_q <= '0;
    end else if (busy_q) begin
      rad_q  <= {rad_q[15:0], 2'b00};
      rem_q  <= rem_n;
      root_q <= root_n;
      cnt_q  <= cnt_q + 4'd1;
      if (cnt_q == LastIter) busy_q <= 1'b0;
    end
  end

  // The final root is presented combinationally on the last iteration cycle.
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LastIter);
  assign root = root_n;

endmodule

// File: rtl/swap_gain_eval.sv
// Evaluates one 2-opt vertex swap: sums old and new path edge lengths and reports the gain.
module swap_gain_eval
  import swap_gain_eval_pkg::*;
#(
  parameter bit ADJACENT = 1'b0
) (
  input logic            clk,
  input logic            rst,
  swap_gain_eval_if.slave bus
);
  localparam logic [2:0] LastEdge = ADJACENT ? 3'd3 : 3'd7;
  localparam logic [2:0] FirstNew = ADJACENT ? 3'd2 : 3'd4;

  state_e     state_q, state_d;
  coord_t     xs_q [NUM_PTS];
  coord_t     ys_q [NUM_PTS];
  logic [2:0] edge_q, edge_d;
  logic       setup_q, setup_d;
  cost_t      old_q, old_d, new_q, new_d, diff_q, diff_d;
  logic       res_q, res_d, complete_q, complete_d;

  pair_t      pr;
  coord_t     dx, dy;
  logic [15:0] sqx, sqy;
  rad_t       radicand;
  logic       sqrt_start, sqrt_busy, sqrt_done;
  dist_t      root;

  swap_gain_eval_isqrt u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (sqrt_start),
    .radicand (radicand),
    .busy     (sqrt_busy),
    .done     (sqrt_done),
    .root     (root)
  );

  always_comb begin
    pr       = edge_pair(ADJACENT, edge_q);
    dx       = abs_diff(xs_q[pr.p], xs_q[pr.q]);
    dy       = abs_diff(ys_q[pr.p], ys_q[pr.q]);
    sqx      = {8'd0, dx} * {8'd0, dx};
    sqy      = {8'd0, dy} * {8'd0, dy};
    radicand = {1'b0, sqx} + {1'b0, sqy};

    state_d    = state_q;
    edge_d     = edge_q;
    setup_d    = setup_q;
    old_d      = old_q;
    new_d      = new_q;
    res_d      = res_q;
    diff_d     = diff_q;
    complete_d = complete_q;
    sqrt_start = 1'b0;

    unique case (state_q)
      // First cycle out of reset doubles as the setup cycle of edge 0.
      StReset: begin
        sqrt_start = 1'b1;
        state_d    = StEdge;
      end
      StEdge: begin
        if (setup_q && !sqrt_busy) begin
          sqrt_start = 1'b1;
          setup_d    = 1'b0;
        end
        if (sqrt_done) begin
          if (edge_q < FirstNew) old_d = old_q + {23'd0, root};
          else                   new_d = new_q + {23'd0, root};
          setup_d = 1'b1;
          if (edge_q == LastEdge) state_d = StCmp;
          else                    edge_d  = edge_q + 3'd1;
        end
      end
      StCmp: begin
        res_d      = new_q < old_q;
        diff_d     = (new_q < old_q) ? old_q - new_q : '0;
        complete_d = 1'b1;
        state_d    = StDone;
      end
      StDone:  state_d = StDone;
      default: state_d = StReset;
    endcase

    if (rst) begin
      state_d    = StReset;
      edge_d     = '0;
      setup_d    = 1'b0;
      old_d      = '0;
      new_d      = '0;
      res_d      = 1'b0;
      diff_d     = '0;
      complete_d = 1'b0;
      sqrt_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xs_q <= bus.x;
      ys_q <= bus.y;
    end
    state_q    <= state_d;
    edge_q     <= edge_d;
    setup_q    <= setup_d;
    old_q      <= old_d;
    new_q      <= new_d;
    res_q      <= res_d;
    diff_q     <= diff_d;
    complete_q <= complete_d;
  end

  assign bus.res        = res_q;
  assign bus.complete   = complete_q;
  assign bus.difference = diff_q;

endmodule

// File: tb/tb_swap_gain_eval.sv
// Randomised and directed bench for both swap_gain_eval variants against a path-length model.
module tb_swap_gain_eval;
  import swap_gain_eval_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;

  swap_gain_eval_if if0 ();
  swap_gain_eval_if if1 ();

  swap_gain_eval #(.ADJACENT(1'b0)) dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));
  swap_gain_eval #(.ADJACENT(1'b1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

  int n_checks = 0;
  int n_bad    = 0;

  function automatic int isqrt_ref(input int s);
    int r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  function automatic int dist_ref(input int xa, input int ya, input int xb, input int yb);
    return isqrt_ref((xa - xb) * (xa - xb) + (ya - yb) * (ya - yb));
  endfunction

  // Path lengths straight from the swap definition; points numbered 1..6 map to index 0..5.
  task automatic model(input bit adj, input int xs[6], input int ys[6],
                       output bit r, output int d);
    int old_len, new_len;
    if (adj) begin
      old_len = dist_ref(xs[0], ys[0], xs[1], ys[1]) + dist_ref(xs[2], ys[2], xs[3], ys[3]);
      new_len = dist_ref(xs[0], ys[0], xs[2], ys[2]) + dist_ref(xs[1], ys[1], xs[3], ys[3]);
    end else begin
      old_len = dist_ref(xs[0], ys[0], xs[1], ys[1]) + dist_ref(xs[1], ys[1], xs[2], ys[2])
              + dist_ref(xs[3], ys[3], xs[4], ys[4]) + dist_ref(xs[4], ys[4], xs[5], ys[5]);
      new_len = dist_ref(xs[0], ys[0], xs[4], ys[4]) + dist_ref(xs[4], ys[4], xs[2], ys[2])
              + dist_ref(xs[3], ys[3], xs[1], ys[1]) + dist_ref(xs[1], ys[1], xs[5], ys[5]);
    end
    r = new_len < old_len;
    d = r ? old_len - new_len : 0;
  endtask

  function automatic logic get_complete(input bit adj);
    return adj ? if1.complete : if0.complete;
  endfunction
  function automatic logic get_res(input bit adj);
    return adj ? if1.res : if0.res;
  endfunction
  function automatic int get_diff(input bit adj);
    return adj ? int'(if1.difference) : int'(if0.difference);
  endfunction

  task automatic drive(input bit adj, input int xs[6], input int ys[6], input logic r);
    for (int i = 0; i < 6; i++) begin
      if (adj) begin
        if1.x[i] = xs[i][7:0];
        if1.y[i] = ys[i][7:0];
      end else begin
        if0.x[i] = xs[i][7:0];
        if0.y[i] = ys[i][7:0];
      end
    end
    if (adj) rst1 = r;
    else     rst0 = r;
  endtask

  task automatic set_rst(input bit adj, input logic r);
    if (adj) rst1 = r;
    else     rst0 = r;
  endtask

  task automatic start_eval(input bit adj, input int xs[6], input int ys[6]);
    @(negedge clk);
    drive(adj, xs, ys, 1'b1);
    @(negedge clk);
    set_rst(adj, 1'b0);
  endtask

  // Counts cycles from the first edge with rst low; lat stays -1 if complete never rises.
  task automatic wait_done(input bit adj, output int lat, output bit r, output int d);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (get_complete(adj) === 1'b1) begin
        lat = c;
        break;
      end
    end
    r = get_res(adj);
    d = get_diff(adj);
  endtask

  task automatic random_pts(output int xs[6], output int ys[6]);
    bit narrow = $urandom_range(0, 1) == 1;
    for (int i = 0; i < 6; i++) begin
      xs[i] = narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      ys[i] = narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
    end
  endtask

  task automatic test_reset;
    int xs[6] = '{0, 200, 0, 200, 0, 200};
    int ys[6] = '{0, 0, 0, 0, 0, 0};
    bit seen = 1'b0;
    @(negedge clk);
    drive(1'b0, xs, ys, 1'b1);
    drive(1'b1, xs, ys, 1'b1);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      seen |= (if0.complete !== 1'b0) || (if1.complete !== 1'b0);
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL held_rst_complete got=%0b want=0", seen);
    end
    for (int a = 0; a < 2; a++) begin
      n_checks++;
      if (get_complete(a[0]) !== 1'b0) begin
        n_bad++; $display("FAIL reset_complete adj=%0d got=%0b want=0", a, get_complete(a[0]));
      end
      n_checks++;
      if (get_res(a[0]) !== 1'b0) begin
        n_bad++; $display("FAIL reset_res adj=%0d got=%0b want=0", a, get_res(a[0]));
      end
      n_checks++;
      if (get_diff(a[0]) !== 0) begin
        n_bad++; $display("FAIL reset_diff adj=%0d got=%0d want=0", a, get_diff(a[0]));
      end
    end
  endtask

  task automatic test_directed;
    bit tadj[6];
    int tx[6][6];
    int ty[6][6];
    int ted[6];
    int xs[6], ys[6];
    int lat, d, want_lat;
    bit r;
    tadj[0] = 1; tx[0] = '{0, 10, 5, 15, 0, 0};   ty[0] = '{0, 0, 0, 0, 0, 0};       ted[0] = 10;
    tadj[1] = 1; tx[1] = '{0, 5, 10, 15, 0, 0};   ty[1] = '{0, 0, 0, 0, 0, 0};       ted[1] = 0;
    tadj[2] = 1; tx[2] = '{0, 255, 0, 255, 0, 0}; ty[2] = '{0, 255, 0, 255, 0, 0};   ted[2] = 720;
    tadj[3] = 1; tx[3] = '{0, 1, 0, 5, 0, 0};     ty[3] = '{0, 1, 0, 5, 0, 0};       ted[3] = 3;
    tadj[4] = 0; tx[4] = '{0, 200, 0, 200, 0, 200}; ty[4] = '{0, 0, 0, 0, 0, 0};     ted[4] = 800;
    tadj[5] = 0; tx[5] = '{0, 30, 0, 0, 0, 0};    ty[5] = '{0, 40, 0, 0, 0, 0};      ted[5] = 0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 6; i++) begin
        xs[i] = tx[k][i];
        ys[i] = ty[k][i];
      end
      want_lat = tadj[k] ? 41 : 81;
      start_eval(tadj[k], xs, ys);
      wait_done(tadj[k], lat, r, d);
      n_checks++;
      if (lat !== want_lat) begin
        n_bad++; $display("FAIL directed_latency vec=%0d got=%0d want=%0d", k, lat, want_lat);
      end
      n_checks++;
      if (r !== (ted[k] > 0)) begin
        n_bad++; $display("FAIL directed_res vec=%0d got=%0b want=%0b", k, r, ted[k] > 0);
      end
      n_checks++;
      if (d !== ted[k]) begin
        n_bad++; $display("FAIL directed_diff vec=%0d got=%0d want=%0d", k, d, ted[k]);
      end
    end
  endtask

  task automatic test_random;
    int xs[6], ys[6];
    int lat, d, md;
    bit r, mr;
    for (int a = 0; a < 2; a++) begin
      for (int k = 0; k < 10; k++) begin
        random_pts(xs, ys);
        model(a[0], xs, ys, mr, md);
        start_eval(a[0], xs, ys);
        wait_done(a[0], lat, r, d);
        n_checks++;
        if (lat !== (a == 1 ? 41 : 81)) begin
          n_bad++; $display("FAIL random_latency adj=%0d got=%0d want=%0d", a, lat, a == 1 ? 41 : 81);
        end
        n_checks++;
        if (r !== mr) begin
          n_bad++; $display("FAIL random_res adj=%0d got=%0b want=%0b", a, r, mr);
        end
        n_checks++;
        if (d !== md) begin
          n_bad++; $display("FAIL random_diff adj=%0d got=%0d want=%0d", a, d, md);
        end
      end
    end
  endtask

  task automatic test_midop_reset;
    int xa[6], ya[6], xb[6], yb[6];
    int lat, d, md;
    bit r, mr;
    for (int a = 0; a < 2; a++) begin
      random_pts(xa, ya);
      random_pts(xb, yb);
      model(a[0], xb, yb, mr, md);
      start_eval(a[0], xa, ya);
      repeat (19) @(posedge clk);
      @(negedge clk);
      drive(a[0], xb, yb, 1'b1);
      @(posedge clk);
      #1;
      n_checks++;
      if (get_complete(a[0]) !== 1'b0 || get_res(a[0]) !== 1'b0 || get_diff(a[0]) !== 0) begin
        n_bad++;
        $display("FAIL midop_clear adj=%0d got=%0b/%0b/%0d want=0/0/0", a,
                 get_complete(a[0]), get_res(a[0]), get_diff(a[0]));
      end
      @(negedge clk);
      set_rst(a[0], 1'b0);
      wait_done(a[0], lat, r, d);
      n_checks++;
      if (lat !== (a == 1 ? 41 : 81)) begin
        n_bad++; $display("FAIL midop_latency adj=%0d got=%0d want=%0d", a, lat, a == 1 ? 41 : 81);
      end
      n_checks++;
      if (r !== mr || d !== md) begin
        n_bad++; $display("FAIL midop_result adj=%0d got=%0b/%0d want=%0b/%0d", a, r, d, mr, md);
      end
    end
  endtask

  task automatic test_back_to_back;
    int xg0[6] = '{0, 200, 0, 200, 0, 200};
    int xg1[6] = '{0, 10, 5, 15, 0, 0};
    int yz[6]  = '{0, 0, 0, 0, 0, 0};
    int xs[6], ys[6];
    int lat, d, md, want_d;
    bit r, mr;
    for (int a = 0; a < 2; a++) begin
      want_d = (a == 1) ? 10 : 800;
      start_eval(a[0], (a == 1) ? xg1 : xg0, yz);
      wait_done(a[0], lat, r, d);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (get_complete(a[0]) !== 1'b1 || get_res(a[0]) !== 1'b1 || get_diff(a[0]) !== want_d) begin
        n_bad++;
        $display("FAIL hold_result adj=%0d got=%0b/%0b/%0d want=1/1/%0d", a,
                 get_complete(a[0]), get_res(a[0]), get_diff(a[0]), want_d);
      end
      random_pts(xs, ys);
      model(a[0], xs, ys, mr, md);
      @(negedge clk);
      drive(a[0], xs, ys, 1'b1);
      @(posedge clk);
      #1;
      n_checks++;
      if (get_complete(a[0]) !== 1'b0 || get_res(a[0]) !== 1'b0 || get_diff(a[0]) !== 0) begin
        n_bad++;
        $display("FAIL restart_clear adj=%0d got=%0b/%0b/%0d want=0/0/0", a,
                 get_complete(a[0]), get_res(a[0]), get_diff(a[0]));
      end
      @(negedge clk);
      set_rst(a[0], 1'b0);
      wait_done(a[0], lat, r, d);
      n_checks++;
      if (lat !== (a == 1 ? 41 : 81) || r !== mr || d !== md) begin
        n_bad++;
        $display("FAIL restart_result adj=%0d got=%0d/%0b/%0d want=%0d/%0b/%0d", a,
                 lat, r, d, a == 1 ? 41 : 81, mr, md);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_midop_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
